// File: rtl/uart_rx_buffered.sv
// 8N1 serial receiver feeding a circular byte FIFO with sticky overflow and
// framing-error flags for the UART register block.
module uart_rx_buffered #(
    parameter int frequency  = 50_000_000,
    parameter int bps        = 115_200,
    parameter int depth_log2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        serial_in,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic        rvalid,
    output logic [15:0] ravail,
    output logic        overflow,
    output logic        frame_err,
    input  logic        clear_err
);

    localparam int DIV   = frequency / bps;
    localparam int TW    = $clog2(DIV) + 1;
    localparam int DEPTH = 1 << depth_log2;

    localparam logic [TW-1:0]         T_HALF  = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0]         T_FULL  = TW'(DIV - 1);
    localparam logic [TW-1:0]         T_ONE   = TW'(1);
    localparam logic [depth_log2:0]   C_FULL  = (depth_log2 + 1)'(DEPTH);
    localparam logic [depth_log2:0]   C_ONE   = (depth_log2 + 1)'(1);
    localparam logic [depth_log2-1:0] P_ONE   = depth_log2'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          meta_q, s;
    logic          push, frame_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            s      <= 1'b1;
        end else begin
            meta_q <= serial_in;
            s      <= meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Each state waits for timer 0 before sampling, so samples land mid-bit.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!s) begin
                    state_d = START;
                    timer_d = T_HALF;
                end
            end
            START: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else if (s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    timer_d = T_FULL;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else begin
                    shift_d[idx_q] = s;
                    timer_d        = T_FULL;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else if (s) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    frame_evt = 1'b1;
                    state_d   = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Consumer handshake: a byte leaves the FIFO on every edge where
    // pop && rvalid; pop while rvalid is low has no effect.
    logic [7:0]            mem [DEPTH];
    logic [depth_log2-1:0] wr_ptr, rd_ptr;
    logic [depth_log2:0]   count;
    logic                  do_pop, do_push, ovf_evt;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != C_FULL) || do_pop);
    assign ovf_evt = push && (count == C_FULL) && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + P_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
            if (do_push && !do_pop) begin
                count <= count + C_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovf_evt)        overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (frame_evt)      frame_err <= 1'b1;
            else if (clear_err) frame_err <= 1'b0;
        end
    end

    assign rvalid = (count != '0);
    assign rdata  = rvalid ? mem[rd_ptr] : 8'h00;
    assign ravail = 16'(count);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered at DIV=16: frames are bit-banged onto serial_in and
// the FIFO contents are checked against a queue of expected bytes.
module tb_uart_rx_buffered;

    localparam int FREQ  = 1_600_000;
    localparam int BPS   = 100_000;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        serial_in = 1'b1;
    logic        pop = 1'b0;
    logic        clear_err = 1'b0;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [15:0] ravail;
    logic        overflow;
    logic        frame_err;

    uart_rx_buffered #(
        .frequency (FREQ),
        .bps       (BPS),
        .depth_log2(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .serial_in(serial_in),
        .pop      (pop),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .ravail   (ravail),
        .overflow (overflow),
        .frame_err(frame_err),
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         m_ferr;
    int         n_cmp;
    int         n_bad;

    typedef struct {
        logic [7:0] data;
        int         exp_ravail;
        bit         exp_ovf;
    } vec_t;
    vec_t vecs[17];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check({tag, ".ravail"},    32'(ravail),    32'(exp_q.size()));
        check({tag, ".rvalid"},    32'(rvalid),    32'(exp_q.size() != 0));
        check({tag, ".rdata"},     32'(rdata),     32'(head));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    endtask

    // Drives one 160-cycle frame; pop_at >= 0 raises pop for that cycle of the frame.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int pop_at);
        int b;
        logic [7:0] head;
        for (int c = 0; c < 160; c++) begin
            b = c / 16;
            if (b == 0)      serial_in = 1'b0;
            else if (b <= 8) serial_in = data[b-1];
            else             serial_in = stop;
            if (c == pop_at) begin
                head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
                check("frame_pop.head", 32'(rdata), 32'(head));
                pop = 1'b1;
            end else begin
                pop = 1'b0;
            end
            tick();
        end
        pop = 1'b0;
        if (pop_at >= 0 && exp_q.size() != 0) void'(exp_q.pop_front());
        if (stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data);
            else m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic pop_byte(input string tag);
        logic [7:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check({tag, ".head"}, 32'(rdata), 32'(head));
        pop = 1'b1;
        tick();
        pop = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check_state(tag);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 17; i++) begin
            vecs[i].data       = 8'(i);
            vecs[i].exp_ravail = (i < 16) ? i + 1 : 16;
            vecs[i].exp_ovf    = (i == 16);
        end

        rst_n = 1'b0;
        serial_in = 1'b1;
        repeat (3) tick();
        check_state("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (100) tick();
            check_state("idle");
        end

        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hA3, 1'b1, -1);
        check("two.ravail", 32'(ravail), 32'd2);
        check("two.rdata", 32'(rdata), 32'h55);
        check_state("two");
        pop_byte("pop1");
        check("pop1.rdata", 32'(rdata), 32'hA3);
        pop_byte("pop2");
        check("pop2.rvalid", 32'(rvalid), 32'd0);
        pop_byte("pop_empty");

        serial_in = 1'b0;
        repeat (4) tick();
        serial_in = 1'b1;
        repeat (40) tick();
        check_state("glitch");

        send_frame(8'h7E, 1'b0, -1);
        repeat (200) tick();
        serial_in = 1'b1;
        repeat (32) tick();
        check_state("break");
        send_frame(8'h31, 1'b1, -1);
        repeat (4) tick();
        check_state("after_break");
        check("after_break.rdata", 32'(rdata), 32'h31);
        clear_err = 1'b1;
        m_ferr = 1'b0;
        tick();
        clear_err = 1'b0;
        check_state("clear_ferr");
        pop_byte("pop31");

        for (int i = 0; i < 17; i++) begin
            send_frame(vecs[i].data, 1'b1, -1);
            check("fill.ravail", 32'(ravail), 32'(vecs[i].exp_ravail));
            check("fill.overflow", 32'(overflow), 32'(vecs[i].exp_ovf));
        end
        check_state("full");
        for (int i = 0; i < 16; i++) pop_byte("drain");
        clear_err = 1'b1;
        m_ovf = 1'b0;
        tick();
        clear_err = 1'b0;
        check_state("clear_ovf");

        for (int i = 0; i < 16; i++) send_frame(8'(8'h80 + i), 1'b1, -1);
        check_state("refill");
        send_frame(8'h99, 1'b1, 154);
        check_state("push_pop_full");
        for (int i = 0; i < 16; i++) pop_byte("drain2");

        send_frame(8'hF0, 1'b0, -1);
        serial_in = 1'b1;
        repeat (20) tick();
        send_frame(8'h5A, 1'b1, -1);
        check_state("pre_rst");
        serial_in = 1'b0;
        repeat (60) tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        check_state("async_rst");
        serial_in = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check_state("post_rst_idle");
        send_frame(8'h3C, 1'b1, -1);
        check_state("post_rst");
        pop_byte("pop3c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
